mem_arbiter: RTL

- Shares the single mem_system instance between the instruction-fetch requester and the data-memory (load/store) requester of the pipeline.
- Captures one request at a time and issues a one-cycle Rd/Wr pulse to mem_system.
- Waits for Done, then returns the read data and a one-cycle done pulse to the granted requester.
- Data side has priority. A starvation guard forces a fetch grant after a bounded run of data grants.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_fsm.sv | 88 ++++++++
 rtl/mem_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W        = 16;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned DEF_MAX_D_RUN = 4;
  localparam int unsigned DEF_TIMEOUT   = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_fsm.sv
// Arbiter control: state/owner registers, grant selection, data-run and WAIT timeout counters.
module mem_arb_fsm
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_RUN = DEF_MAX_D_RUN,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_req,
  input  logic   i_d_req,
  input  logic   i_mem_done,
  output owner_t o_owner,
  output logic   o_grant_i_c,
  output logic   o_grant_d_c,
  output logic   o_capture_c,
  output logic   o_timeout_c
);

  localparam int unsigned RUN_W = $clog2(MAX_D_RUN + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  state_t           r_state, w_state_n;
  owner_t           r_owner, w_owner_n;
  logic [RUN_W-1:0] r_run,   w_run_n;
  logic [TO_W-1:0]  r_tcnt,  w_tcnt_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_I;
      r_run   <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_n;
      r_owner <= w_owner_n;
      r_run   <= w_run_n;
      r_tcnt  <= w_tcnt_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_owner_n   = r_owner;
    w_run_n     = r_run;
    w_tcnt_n    = r_tcnt;
    o_grant_i_c = 1'b0;
    o_grant_d_c = 1'b0;
    o_capture_c = 1'b0;
    o_timeout_c = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Data wins unless it has already used up its run while fetch waits
        if (i_d_req && ((r_run < RUN_W'(MAX_D_RUN)) || !i_req)) begin
          o_grant_d_c = 1'b1;
          w_owner_n   = OWN_D;
          w_state_n   = ST_ISSUE;
          if (i_req && (r_run != RUN_W'(MAX_D_RUN))) w_run_n = r_run + RUN_W'(1);
        end else if (i_req) begin
          o_grant_i_c = 1'b1;
          w_owner_n   = OWN_I;
          w_state_n   = ST_ISSUE;
          w_run_n     = '0;
        end
      end
      ST_ISSUE: begin
        w_tcnt_n  = '0;
        w_state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_mem_done) begin
          o_capture_c = 1'b1;
          w_state_n   = ST_RESP;
        end else if (r_tcnt == TO_W'(TIMEOUT - 1)) begin
          o_timeout_c = 1'b1;
          w_state_n   = ST_RESP;
        end else begin
          w_tcnt_n = r_tcnt + TO_W'(1);
        end
      end
      ST_RESP: w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  assign o_owner = r_owner;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mem_system between instruction fetch and load/store; data side has priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_RUN = DEF_MAX_D_RUN,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_stall,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              mem_err,
  output logic              err
);

  logic              w_d_req;
  logic              w_grant_i, w_grant_d, w_capture, w_timeout, w_finish;
  owner_t            w_owner;
  mem_req_t          r_req;
  logic              r_mem_rd, r_mem_wr;
  logic              r_i_done, r_d_done, r_err;
  logic [DATA_W-1:0] r_i_rdata, r_d_rdata;

  assign w_d_req  = d_rd | d_wr;
  assign w_finish = w_capture | w_timeout;

  mem_arb_fsm #(
    .MAX_D_RUN (MAX_D_RUN),
    .TIMEOUT   (TIMEOUT)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_d_req     (w_d_req),
    .i_mem_done  (mem_done),
    .o_owner     (w_owner),
    .o_grant_i_c (w_grant_i),
    .o_grant_d_c (w_grant_d),
    .o_capture_c (w_capture),
    .o_timeout_c (w_timeout)
  );

  // Request latch; the Rd/Wr pulse is raised for exactly the ISSUE cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req    <= '0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
    end else begin
      r_mem_rd <= w_grant_i | (w_grant_d & d_rd);
      r_mem_wr <= w_grant_d & d_wr;
      if (w_grant_d) begin
        r_req <= '{addr: d_addr, wdata: d_wdata};
      end else if (w_grant_i) begin
        r_req <= '{addr: i_addr, wdata: '0};
      end
    end
  end

  // Response path: rdata is kept on timeout, done pulses in RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
    end else begin
      r_i_done <= w_finish & (w_owner == OWN_I);
      r_d_done <= w_finish & (w_owner == OWN_D);
      if (w_capture && (w_owner == OWN_I)) r_i_rdata <= mem_rdata;
      if (w_capture && (w_owner == OWN_D)) r_d_rdata <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else      r_err <= r_err | mem_err | w_timeout;
  end

  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_done    = r_i_done;
  assign d_done    = r_d_done;
  assign mem_addr  = r_req.addr;
  assign mem_wdata = r_req.wdata;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign err       = r_err;
  assign i_stall   = i_req & ~r_i_done;
  assign d_stall   = w_d_req & ~r_d_done;

endmodule
